fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register that sits directly upstream of `controller`. Holds the program counter and drives the instruction-memory address. Latches the fetched 8-bit instruction into `instr`, which feeds `controller`. Consumes `controller`'s `pccontrol` and `flush` outputs to redirect the PC, squash wrong-path instructions and halt.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Holds the program
// counter, presents it as the instruction-memory read address, and latches
// the returned instruction for the downstream controller. The controller's
// pccontrol/flush outputs redirect the PC, squash wrong-path fetches and halt.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_reset         synchronous active-high reset
//   i_stall         freeze PC and IF/ID register
//   i_pccontrol     PC select for the instruction held in o_instr
//   i_flush         squash the instruction being fetched this cycle
//   i_branch_offset signed relative-branch offset
//   i_jump_target   absolute jump target
//   o_imem_addr     instruction-memory address (the PC register)
//   i_imem_data     instruction at o_imem_addr, same cycle
//   o_instr         IF/ID instruction register
//   o_instr_pc      address o_instr was fetched from
//   o_prev_instr    previous value of o_instr
//   o_instr_valid   0 while o_instr holds a reset/flush bubble
//   o_halted        sticky halt flag
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter logic [7:0] NOP_INSTR = 8'h00
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_stall,
   input  logic [2:0] i_pccontrol,
   input  logic       i_flush,
   input  logic [7:0] i_branch_offset,
   input  logic [7:0] i_jump_target,
   output logic [7:0] o_imem_addr,
   input  logic [7:0] i_imem_data,
   output logic [7:0] o_instr,
   output logic [7:0] o_instr_pc,
   output logic [7:0] o_prev_instr,
   output logic       o_instr_valid,
   output logic       o_halted
);

   logic [7:0] r_pc;
   logic [7:0] r_instr;
   logic [7:0] r_instr_pc;
   logic [7:0] r_prev_instr;
   logic       r_instr_valid;
   logic       r_halted;

   logic       w_halt_req;
   logic       w_redirect;
   logic       w_squash;
   logic [7:0] w_next_pc;

   // Decode controller requests; a bubble in IF/ID never redirects, halts or flushes.
   always_comb begin
      w_halt_req = 1'b0;
      w_redirect = 1'b0;
      w_next_pc  = r_pc + 8'd1;
      w_squash   = r_instr_valid & i_flush;
      if (r_instr_valid) begin
         case (i_pccontrol)
            3'b001: begin
               // 8-bit add of the two's-complement offset wraps silently
               w_redirect = 1'b1;
               w_next_pc  = r_instr_pc + i_branch_offset;
            end
            3'b010: begin
               w_redirect = 1'b1;
               w_next_pc  = i_jump_target;
            end
            3'b011: begin
               w_halt_req = 1'b1;
            end
            default: begin
               // sequential and reserved encodings both advance by one
               w_next_pc = r_pc + 8'd1;
            end
         endcase
      end else begin
         w_halt_req = 1'b0;
      end
   end

   // PC and IF/ID register update in priority order: reset, halted, halt, stall, fetch.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= RESET_PC;
         r_prev_instr  <= NOP_INSTR;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else if (r_halted) begin
         r_halted <= 1'b1;
      end else if (w_halt_req) begin
         // halt beats stall; the halting instruction is replaced by a bubble
         r_halted      <= 1'b1;
         r_prev_instr  <= r_instr;
         r_instr       <= NOP_INSTR;
         r_instr_valid <= 1'b0;
      end else if (i_stall) begin
         // holding instr makes the controller re-present any pending redirect
         r_halted <= 1'b0;
      end else begin
         r_pc         <= w_next_pc;
         r_prev_instr <= r_instr;
         r_instr_pc   <= r_pc;
         if (w_squash) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
         end else begin
            r_instr       <= i_imem_data;
            r_instr_valid <= 1'b1;
         end
      end
   end

   assign o_imem_addr   = r_pc;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;
   assign o_prev_instr  = r_prev_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_halted      = r_halted;

   // w_redirect documents decode intent; the next-PC mux already carries its effect
   logic w_unused;
   assign w_unused = w_redirect;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [7:0] RST_PC = 8'h00;
   localparam logic [7:0] NOP    = 8'hE0;

   logic       clk;
   logic       reset;
   logic       stall;
   logic [2:0] pccontrol;
   logic       flush;
   logic [7:0] branch_offset;
   logic [7:0] jump_target;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic [7:0] prev_instr;
   logic       instr_valid;
   logic       halted;

   logic [7:0] mem [256];

   int n_tests;
   int n_fail;

   // behavioural model state
   logic [7:0] m_pc, m_instr, m_ipc, m_prev;
   logic       m_valid, m_halted;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_pccontrol(pccontrol),
      .i_flush(flush), .i_branch_offset(branch_offset), .i_jump_target(jump_target),
      .o_imem_addr(imem_addr), .i_imem_data(imem_data), .o_instr(instr),
      .o_instr_pc(instr_pc), .o_prev_instr(prev_instr), .o_instr_valid(instr_valid),
      .o_halted(halted)
   );

   assign imem_data = mem[imem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock edge of the specification's rules, applied to the model
   task automatic model_step();
      logic [7:0] fetched;
      logic       redirect;
      fetched  = mem[m_pc];
      redirect = m_valid && (pccontrol == 3'd1 || pccontrol == 3'd2);
      if (reset) begin
         m_pc = RST_PC; m_instr = NOP; m_ipc = RST_PC; m_prev = NOP;
         m_valid = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
         // everything frozen
      end else if (m_valid && pccontrol == 3'd3) begin
         m_halted = 1'b1; m_prev = m_instr; m_instr = NOP; m_valid = 1'b0;
      end else if (stall) begin
         // everything frozen
      end else begin
         m_prev = m_instr;
         m_ipc  = m_pc;
         if (m_valid && flush) begin
            m_instr = NOP; m_valid = 1'b0;
         end else begin
            m_instr = fetched; m_valid = 1'b1;
         end
         if (redirect && pccontrol == 3'd1) m_pc = m_ipc_old_plus(branch_offset);
         else if (redirect)                 m_pc = jump_target;
         else                               m_pc = m_pc + 8'd1;
      end
   endtask

   // branch target uses instr_pc as it was before this edge; m_ipc now holds
   // the old PC, so recompute from the saved pre-edge value
   logic [7:0] ipc_before;
   function automatic logic [7:0] m_ipc_old_plus(input logic [7:0] off);
      int sum;
      sum = (int'(ipc_before) + int'($signed(off)) + 256) % 256;
      return sum[7:0];
   endfunction

   task automatic compare_all();
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("prev_instr", prev_instr, m_prev);
      chk("instr_valid", {7'd0, instr_valid}, {7'd0, m_valid});
      chk("halted", {7'd0, halted}, {7'd0, m_halted});
   endtask

   task automatic step();
      @(posedge clk);
      ipc_before = m_ipc;
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic r, input logic s, input logic [2:0] pc,
                        input logic f, input logic [7:0] off, input logic [7:0] tgt);
      reset = r; stall = s; pccontrol = pc; flush = f;
      branch_offset = off; jump_target = tgt;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      m_pc = 8'h5A; m_instr = 8'h5A; m_ipc = 8'h5A; m_prev = 8'h5A;
      m_valid = 1'b1; m_halted = 1'b1; ipc_before = 8'h00;
      drive(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      #1;
      step();
      // reset values
      chk("rst_addr", imem_addr, 8'h00);
      chk("rst_instr", instr, 8'hE0);
      chk("rst_prev", prev_instr, 8'hE0);
      chk("rst_valid", {7'd0, instr_valid}, 8'h00);
      chk("rst_halted", {7'd0, halted}, 8'h00);

      // sequential run with wrap
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      step();
      chk("seq_first_instr", instr, 8'h00);
      chk("seq_first_valid", {7'd0, instr_valid}, 8'h01);
      for (int k = 2; k <= 256; k++) step();
      chk("seq_ff_ipc", instr_pc, 8'hFF);
      step();
      chk("seq_wrap_ipc", instr_pc, 8'h00);
      chk("seq_wrap_valid", {7'd0, instr_valid}, 8'h01);

      // relative branch back from 0x10 with flush
      drive(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      step();
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      for (int k = 0; k < 17; k++) step();
      chk("br_setup_ipc", instr_pc, 8'h10);
      drive(1'b0, 1'b0, 3'd1, 1'b1, 8'hFC, 8'h00);
      step();
      chk("br_bubble", instr, 8'hE0);
      chk("br_bubble_valid", {7'd0, instr_valid}, 8'h00);
      chk("br_target_addr", imem_addr, 8'h0C);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      step();
      chk("br_target_ipc", instr_pc, 8'h0C);

      // absolute jump from 0x10 without flush (delay slot)
      for (int k = 0; k < 4; k++) step();
      chk("jmp_setup_ipc", instr_pc, 8'h10);
      drive(1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'hA5);
      step();
      chk("jmp_slot_instr", instr, 8'h11);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      step();
      chk("jmp_target_instr", instr, 8'hA5);

      // stall three cycles over a pending redirect
      drive(1'b0, 1'b1, 3'd1, 1'b1, 8'h10, 8'h00);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_addr", imem_addr, 8'hA6);
         chk("stall_instr", instr, 8'hA5);
         chk("stall_prev", prev_instr, 8'h11);
      end
      stall = 1'b0;
      step();
      chk("stall_redirect_addr", imem_addr, 8'hB5);
      chk("stall_redirect_prev", prev_instr, 8'hA5);

      // halt, held for 10 cycles regardless of inputs, then reset mid-halt
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      step();
      pccontrol = 3'd3;
      step();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         step();
         chk("halt_flag", {7'd0, halted}, 8'h01);
         chk("halt_addr", imem_addr, 8'hB6);
      end
      drive(1'b1, 1'b1, 3'd3, 1'b1, 8'h00, 8'h00);
      step();
      chk("halt_rst_flag", {7'd0, halted}, 8'h00);
      chk("halt_rst_addr", imem_addr, 8'h00);
      chk("halt_rst_instr", instr, 8'hE0);

      // flush and redirect on a bubble are ignored
      drive(1'b0, 1'b0, 3'd1, 1'b1, 8'h40, 8'h00);
      step();
      chk("bub_flush_instr", instr, 8'h00);
      chk("bub_flush_valid", {7'd0, instr_valid}, 8'h01);
      chk("bub_flush_addr", imem_addr, 8'h01);

      // randomized run against the model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 29) == 0) ? 3'd3 : 3'($urandom_range(0, 7) & 3'h6 | 3'($urandom_range(0, 2) == 1)),
               ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom));
         if (pccontrol == 3'd3 && $urandom_range(0, 1) == 0) pccontrol = 3'd2;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
